audio_adc_receiver: RTL and testbench
=====================================

# audio_adc_receiver

Capture side of the synthesizer's audio codec link. The existing sound path drives the codec's serial DAC; this block receives the serial ADC stream (I2S, codec as master supplying AUD_BCLK and AUD_ADCLRCK), deserializes left/right words in the `clock` domain, and delivers stereo sample pairs through a small FIFO with a valid/ready handshake to the recorder and gui.

## Interface
- DATA_WIDTH, 24: bits per channel word, MSB-first; legal range 8–32.
- FIFO_DEPTH, 4: stereo pairs buffered; power of two, ≥2.

Ports:
- clock  in  1  system clock (CLOCK_50); all state on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- aud_bclk  in  1  codec bit clock, asynchronous to `clock`, ≤ clock/8.
- aud_adclrck  in  1  codec ADC word select; 0 = left, 1 = right.
- aud_adcdat  in  1  codec ADC serial data.
- out_valid  out  1  a stereo pair is at the head of the FIFO.
- out_ready  in  1  consumer accepts the head pair.
- out_left  out  DATA_WIDTH  head pair left word (two's complement).
- out_right  out  DATA_WIDTH  head pair right word.
- overflow  out  1  sticky: a completed pair was dropped.
- clear_overflow  in  1  synchronous clear of `overflow`.

## Operation
- The three codec inputs pass through 2-flop synchronizers; a third register on bclk gives rise = s2 & ~prev.
- On each bclk rise, sample lrck_s and adcdat_s:
  - If lrck_s ≠ lrck_last: channel start; bit_count ← 0; this bit is the I2S delay slot and is discarded; `aligned` ← 1.
  - Else if aligned and bit_count < DATA_WIDTH: shift adcdat_s into the shift register LSB, bit_count++.
  - Bits beyond DATA_WIDTH ignored (codec may send longer slots).
- When bit_count reaches DATA_WIDTH: left channel → left_hold, left_ok ← 1; right channel → if left_ok, push {left_hold, word}, left_ok ← 0; else discard.
- LRCK change before DATA_WIDTH bits: partial word discarded, left_ok ← 0 (pair integrity over sample count).
- After reset, aligned = 0: all data ignored until the first LRCK transition.
- FIFO: show-ahead; pop when out_valid & out_ready. Push when full and no pop in same cycle → pair dropped, overflow ← 1. Push and pop simultaneously while full → both occur, no overflow.
- `overflow` set has priority over clear_overflow in the same cycle.
- out_left/out_right hold stable while out_valid & ~out_ready.

## Timing
- Reset values: out_valid 0, out_left 0, out_right 0, overflow 0, FIFO empty, bit_count 0, left_ok 0, aligned 0, synchronizers 0, lrck_last 0.
- Latency, FIFO empty: edge E0 samples aud_bclk high into s1; E1 s2; E2 right LSB shifted; E3 completion → push; E4 FIFO written; out_valid high after E4 (4 clock edges after E0).
- Throughput: one push per frame; one pop per cycle.
- out_valid deasserts the cycle after the pop of the last entry.
- Reset asserted mid-word or mid-frame: all state cleared immediately; realignment on next LRCK transition.

## Structure
- Shared package `audio_pkg`: DATA_WIDTH default, channel encoding constants (CH_LEFT = 0, CH_RIGHT = 1), FIFO_DEPTH default.
- Sub-module `audio_sample_fifo`: synchronous FIFO of 2·DATA_WIDTH-bit entries with push/pop/full/empty, pointer width log2(FIFO_DEPTH)+1.
- Top holds synchronizers, edge detect, deserializer counters, and left hold register.

## Test plan
- Codec model at clock/16 BCLK, 32-bit slots, left=24'h123456, right=24'hABCDEF → one pair, out_left 24'h123456, out_right 24'hABCDEF, out_valid 4 edges after right-LSB BCLK sample.
- out_ready low, 5 frames, FIFO_DEPTH 4 → first 4 pairs retained in order, 5th dropped, overflow 1; clear_overflow → 0.
- Stream starts mid-right-slot after reset → no output until the first full left+right frame; first pair correct.
- LRCK toggles after 10 bits of a left word → no pair that frame; next full frame delivered intact.
- FIFO full, out_ready high on the cycle of a push → pop and push both occur, overflow stays 0, order preserved.
- Reset pulsed mid right word → outputs return to reset values; next full frame after realignment correct.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants for the codec ADC capture path.
package audio_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 24;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  // LRCK level meaning.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Bits needed for a counter that must reach `width` itself.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead synchronous FIFO holding stereo sample pairs.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned Width = 2 * DATA_WIDTH_DEFAULT,
  parameter int unsigned Depth = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign data_o = mem_q[rd_ptr_q[AddrW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; cleared so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/audio_adc_receiver.sv
// I2S ADC receiver: synchronizes the codec lines, deserializes left/right words
// and queues complete stereo pairs for a valid/ready consumer.
module audio_adc_receiver
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  aud_bclk,
  input  logic                  aud_adclrck,
  input  logic                  aud_adcdat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int unsigned CntW = count_width(DATA_WIDTH);

  logic bclk_s1_q, bclk_s2_q, bclk_prev_q;
  logic lrck_s1_q, lrck_s2_q;
  logic dat_s1_q, dat_s2_q;

  logic [CntW-1:0]         bit_count_q, bit_count_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   left_hold_q, left_hold_d;
  logic [2*DATA_WIDTH-1:0] pair_q, pair_d;
  logic lrck_last_q, lrck_last_d;
  logic aligned_q, aligned_d;
  logic done_q, done_d;
  logic left_ok_q, left_ok_d;
  logic push_q, push_d;
  logic overflow_q, overflow_d;

  logic                    bclk_rise, word_full;
  logic                    fifo_full, fifo_empty, pop, drop;
  logic [2*DATA_WIDTH-1:0] fifo_data;

  // Two-flop synchronizers plus a history flop on bclk for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      dat_s1_q    <= 1'b0;
      dat_s2_q    <= 1'b0;
    end else begin
      bclk_s1_q   <= aud_bclk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_prev_q <= bclk_s2_q;
      lrck_s1_q   <= aud_adclrck;
      lrck_s2_q   <= lrck_s1_q;
      dat_s1_q    <= aud_adcdat;
      dat_s2_q    <= dat_s1_q;
    end
  end

  assign bclk_rise = bclk_s2_q & ~bclk_prev_q;
  assign word_full = (bit_count_q == CntW'(DATA_WIDTH));

  // Deserializer and pair assembly next-state.
  always_comb begin
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    pair_d      = pair_q;
    lrck_last_d = lrck_last_q;
    aligned_d   = aligned_q;
    done_d      = done_q;
    left_ok_d   = left_ok_q;
    push_d      = 1'b0;

    // Word completion is handled once, the cycle after its last bit lands.
    if (aligned_q && word_full && !done_q) begin
      done_d = 1'b1;
      if (lrck_last_q == CH_LEFT) begin
        left_hold_d = shift_q;
        left_ok_d   = 1'b1;
      end else if (lrck_last_q == CH_RIGHT) begin
        if (left_ok_q) begin
          push_d = 1'b1;
          pair_d = {left_hold_q, shift_q};
        end
        left_ok_d = 1'b0;
      end
    end

    if (bclk_rise) begin
      if (lrck_s2_q != lrck_last_q) begin
        // Channel start: this bit is the I2S delay slot and carries no data.
        lrck_last_d = lrck_s2_q;
        bit_count_d = '0;
        aligned_d   = 1'b1;
        done_d      = 1'b0;
        // A truncated word breaks the pair; never join halves of different frames.
        if (!word_full) left_ok_d = 1'b0;
      end else if (aligned_q && !word_full) begin
        shift_d     = {shift_q[DATA_WIDTH-2:0], dat_s2_q};
        bit_count_d = bit_count_q + CntW'(1);
      end
    end
  end

  // Deserializer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_count_q <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      pair_q      <= '0;
      lrck_last_q <= CH_LEFT;
      aligned_q   <= 1'b0;
      done_q      <= 1'b0;
      left_ok_q   <= 1'b0;
      push_q      <= 1'b0;
    end else begin
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      pair_q      <= pair_d;
      lrck_last_q <= lrck_last_d;
      aligned_q   <= aligned_d;
      done_q      <= done_d;
      left_ok_q   <= left_ok_d;
      push_q      <= push_d;
    end
  end

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign drop      = push_q & fifo_full & ~pop;

  audio_sample_fifo #(
    .Width(2 * DATA_WIDTH),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_ni (reset),
    .push_i (push_q),
    .data_i (pair_q),
    .pop_i  (pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign {out_left, out_right} = fifo_data;

  // Sticky overflow; a drop in the same cycle wins over the clear.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  // Overflow register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Bench for audio_adc_receiver: codec model at clock/16 BCLK with 32-bit slots,
// a frame-level model of expected pairs, and a per-cycle compare process.
module tb_audio_adc_receiver;
  import audio_pkg::*;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset, aud_bclk, aud_adclrck, aud_adcdat;
  logic          out_valid, out_ready, overflow, clear_overflow;
  logic [DW-1:0] out_left, out_right;

  audio_adc_receiver #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .aud_bclk      (aud_bclk),
    .aud_adclrck   (aud_adclrck),
    .aud_adcdat    (aud_adcdat),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_left      (out_left),
    .out_right     (out_right),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Expected-output model state.
  int              cyc = 0;
  int              push_at = -1;
  int              lsb_cyc = 0;
  int              rise_cyc = -1;
  int              pops = 0;
  logic [2*DW-1:0] push_val;
  logic [2*DW-1:0] exp_q[$];
  logic            exp_ovf = 1'b0;
  logic            prev_valid = 1'b0;
  logic [DW-1:0]   last_l = '0;
  logic [DW-1:0]   last_r = '0;

  // Word-level view of the link as the codec sends it.
  logic          m_last, m_aligned, m_left_ok, m_prev_complete;
  logic [DW-1:0] m_hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last          = CH_LEFT;
    m_aligned       = 1'b0;
    m_left_ok       = 1'b0;
    m_prev_complete = 1'b0;
    m_hold          = '0;
  endtask

  // One BCLK period: data changes with the falling edge, rising edge left asserted.
  task automatic drive_bit(input logic lr, input logic d);
    repeat (8) @(negedge clock);
    aud_bclk    = 1'b0;
    aud_adclrck = lr;
    aud_adcdat  = d;
    repeat (8) @(negedge clock);
    aud_bclk = 1'b1;
  endtask

  // Slot = delay bit, nbits MSB-first data bits of w, pad filler bits.
  task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int nbits,
                           input int pad, input bit pulse_ready);
    if (ch != m_last) begin
      if (!m_prev_complete) m_left_ok = 1'b0;
      m_aligned = 1'b1;
      m_last    = ch;
    end
    drive_bit(ch, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(ch, w[DW-1-i]);
      if (i == DW - 1 && m_aligned) begin
        if (ch == CH_LEFT) begin
          m_hold    = w;
          m_left_ok = 1'b1;
        end else begin
          if (m_left_ok) begin
            push_val = {m_hold, w};
            lsb_cyc  = cyc;
            push_at  = cyc + 5;
            if (pulse_ready) begin
              fork
                begin
                  repeat (4) @(negedge clock);
                  out_ready = 1'b1;
                  @(negedge clock);
                  out_ready = 1'b0;
                end
              join_none
            end
          end
          m_left_ok = 1'b0;
        end
      end
    end
    m_prev_complete = (nbits >= DW);
    for (int i = 0; i < pad; i++) drive_bit(ch, 1'b0);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit pulse);
    send_slot(CH_LEFT, l, DW, 7, 1'b0);
    send_slot(CH_RIGHT, r, DW, 7, pulse);
  endtask

  // Per-cycle compare against the model.
  always @(posedge clock) begin : compare
    logic          hs, clr;
    logic [DW-1:0] hs_l, hs_r;
    hs   = out_valid & out_ready;
    clr  = clear_overflow;
    hs_l = out_left;
    hs_r = out_right;
    cyc++;
    #1;
    if (!reset) begin
      exp_q.delete();
      exp_ovf    = 1'b0;
      push_at    = -1;
      prev_valid = 1'b0;
    end else begin
      if (clr) exp_ovf = 1'b0;
      if (hs && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pops++;
        last_l = hs_l;
        last_r = hs_r;
      end
      if (cyc == push_at) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(push_val);
        else exp_ovf = 1'b1;
        push_at = -1;
      end
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("head_left", 64'(out_left), 64'(exp_q[0][2*DW-1:DW]));
        check("head_right", 64'(out_right), 64'(exp_q[0][DW-1:0]));
      end
      check("overflow", 64'(overflow), 64'(exp_ovf));
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
    end
  end

  logic [DW-1:0] ovl [5];
  logic [DW-1:0] ovr [5];
  logic [DW-1:0] fl  [5];
  logic [DW-1:0] fr  [5];
  int            pops0;

  initial begin
    ovl = '{24'h000001, 24'h000002, 24'h000003, 24'h000004, 24'h000005};
    ovr = '{24'hFFFFF1, 24'hFFFFF2, 24'hFFFFF3, 24'hFFFFF4, 24'hFFFFF5};
    fl  = '{24'h100000, 24'h200000, 24'h300000, 24'h400000, 24'h500000};
    fr  = '{24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D, 24'h0E0E0E};
    reset = 1'b0; aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
    out_ready = 1'b0; clear_overflow = 1'b0;
    model_reset();
    repeat (5) @(negedge clock);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_left", 64'(out_left), 64'd0);
    check("rst_right", 64'(out_right), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Stream joins mid right slot; first full frame is the first pair.
    rise_cyc = -1;
    send_slot(CH_RIGHT, 24'h5A5A5A, 15, 0, 1'b0);
    send_frame(24'h123456, 24'hABCDEF, 1'b0);
    check("latency", 64'(rise_cyc - lsb_cyc), 64'd5);
    check("first_left", 64'(out_left), 64'h123456);
    check("first_right", 64'(out_right), 64'hABCDEF);
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    out_ready = 1'b0;
    check("first_popped_l", 64'(last_l), 64'h123456);
    check("first_popped_r", 64'(last_r), 64'hABCDEF);
    check("first_empty", 64'(out_valid), 64'd0);

    // Five frames with no consumer: four kept, fifth dropped.
    pops0 = pops;
    for (int i = 0; i < 5; i++) send_frame(ovl[i], ovr[i], 1'b0);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_head_l", 64'(out_left), 64'(ovl[0]));
    check("ovf_head_r", 64'(out_right), 64'(ovr[0]));
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    @(negedge clock);
    check("ovf_cleared", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    repeat (8) @(negedge clock);
    out_ready = 1'b0;
    check("ovf_pops", 64'(pops - pops0), 64'd4);
    check("ovf_last_l", 64'(last_l), 64'(ovl[3]));
    check("ovf_last_r", 64'(last_r), 64'(ovr[3]));

    // Truncated words break pairing; the next whole frame is intact.
    out_ready = 1'b1;
    pops0 = pops;
    send_slot(CH_LEFT, 24'h111111, DW, 7, 1'b0);
    send_slot(CH_RIGHT, 24'h222222, 10, 0, 1'b0);
    send_slot(CH_LEFT, 24'h333333, 10, 0, 1'b0);
    send_slot(CH_RIGHT, 24'h444444, DW, 7, 1'b0);
    check("trunc_nopair", 64'(pops - pops0), 64'd0);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    repeat (4) @(negedge clock);
    check("trunc_pops", 64'(pops - pops0), 64'd1);
    check("trunc_l", 64'(last_l), 64'h0F0F0F);
    check("trunc_r", 64'(last_r), 64'hF0F0F0);
    out_ready = 1'b0;

    // Full FIFO with a pop on the push cycle: both happen, no overflow.
    pops0 = pops;
    for (int i = 0; i < 4; i++) send_frame(fl[i], fr[i], 1'b0);
    send_frame(fl[4], fr[4], 1'b1);
    check("simul_ovf", 64'(overflow), 64'd0);
    check("simul_head_l", 64'(out_left), 64'(fl[1]));
    check("simul_pops", 64'(pops - pops0), 64'd1);
    out_ready = 1'b1;
    repeat (8) @(negedge clock);
    out_ready = 1'b0;
    check("simul_total", 64'(pops - pops0), 64'd5);
    check("simul_last_l", 64'(last_l), 64'(fl[4]));
    check("simul_last_r", 64'(last_r), 64'(fr[4]));

    // Reset in the middle of a right word with a pair queued.
    send_frame(24'hCAFE01, 24'hBEEF02, 1'b0);
    send_slot(CH_LEFT, 24'h777777, DW, 7, 1'b0);
    send_slot(CH_RIGHT, 24'h888888, 12, 0, 1'b0);
    @(negedge clock);
    reset = 1'b0; aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
    model_reset();
    @(negedge clock);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_left", 64'(out_left), 64'd0);
    check("mid_rst_right", 64'(out_right), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    pops0 = pops;
    send_slot(CH_LEFT, 24'h999999, DW, 7, 1'b0);
    send_slot(CH_RIGHT, 24'hAAAAAA, DW, 7, 1'b0);
    check("realign_nopair", 64'(out_valid), 64'd0);
    send_frame(24'h13579B, 24'h2468AC, 1'b0);
    check("realign_l", 64'(out_left), 64'h13579B);
    check("realign_r", 64'(out_right), 64'h2468AC);
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    out_ready = 1'b0;
    check("realign_pops", 64'(pops - pops0), 64'd1);
    check("realign_empty", 64'(out_valid), 64'd0);

    repeat (4) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
